// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 control unit: FSM states, opcodes, datapath
// select codes and the bundled control word driven into the datapath.
package lc3_pkg;

  typedef enum logic [4:0] {
    S_INIT, S_F1, S_F2, S_F3, S_DEC, S_EXALU, S_BR, S_JMP, S_JSR1, S_JSR2,
    S_LEA, S_LDA, S_LDRA, S_STA, S_STRA, S_MRD, S_MWB, S_SD, S_SW, S_HALT
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010,
                         OP_ST  = 4'b0011, OP_JSR = 4'b0100, OP_AND = 4'b0101,
                         OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001,
                         OP_JMP = 4'b1100, OP_LEA = 4'b1110;

  localparam logic [1:0] ALU_ADD = 2'b00, ALU_AND = 2'b01, ALU_NOT = 2'b10, ALU_PASS = 2'b11;
  localparam logic [1:0] PC_INC = 2'b00, PC_EAB = 2'b01, PC_BUS = 2'b10;
  localparam logic [1:0] EAB2_ZERO = 2'b00, EAB2_OFF6 = 2'b01, EAB2_OFF9 = 2'b10, EAB2_OFF11 = 2'b11;
  localparam logic EAB1_PC = 1'b0, EAB1_RA = 1'b1;
  localparam logic MAR_EAB = 1'b0, MAR_ZEXT = 1'b1;
  localparam logic MDR_BUS = 1'b0, MDR_MEM = 1'b1;

  typedef struct packed {
    logic [1:0] aluControl;
    logic [2:0] SR1;
    logic [2:0] SR2;
    logic [2:0] DR;
    logic [1:0] selPC;
    logic       selEAB1;
    logic [1:0] selEAB2;
    logic       selMAR;
    logic       selMDR;
    logic       enaALU;
    logic       enaMARM;
    logic       enaPC;
    logic       enaMDR;
    logic       regWE;
    logic       flagWE;
    logic       ldPC;
    logic       ldIR;
    logic       ldMAR;
    logic       ldMDR;
    logic       memWE;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/lc3_control_if.sv
// Control-unit <-> datapath link: IR and flags in, every select/strobe out.
interface lc3_control_if;
  logic [15:0] IR;
  logic        N, Z, P;
  logic [1:0]  aluControl;
  logic [2:0]  SR1, SR2, DR;
  logic [1:0]  selPC;
  logic        selEAB1;
  logic [1:0]  selEAB2;
  logic        selMAR, selMDR;
  logic        enaALU, enaMARM, enaPC, enaMDR;
  logic        regWE, flagWE, ldPC, ldIR, ldMAR, ldMDR, memWE;
  logic        halted;
  logic [15:0] instrCount;

  modport master (
    input  IR, N, Z, P,
    output aluControl, SR1, SR2, DR, selPC, selEAB1, selEAB2, selMAR, selMDR,
           enaALU, enaMARM, enaPC, enaMDR, regWE, flagWE, ldPC, ldIR, ldMAR,
           ldMDR, memWE, halted, instrCount
  );
  modport slave (
    output IR, N, Z, P,
    input  aluControl, SR1, SR2, DR, selPC, selEAB1, selEAB2, selMAR, selMDR,
           enaALU, enaMARM, enaPC, enaMDR, regWE, flagWE, ldPC, ldIR, ldMAR,
           ldMDR, memWE, halted, instrCount
  );
endinterface

// File: rtl/lc3_ctrl_decode.sv
// Combinational map from FSM state (plus IR and flags) to the control word.
module lc3_ctrl_decode
  import lc3_pkg::*;
(
  input  state_e      state_i,
  input  logic [15:0] ir_i,
  input  logic        n_i,
  input  logic        z_i,
  input  logic        p_i,
  output ctrl_t       ctrl_o
);
  logic unused_ir;
  assign unused_ir = ^ir_i[5:3];

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_F1: begin
        ctrl_o.enaMARM = 1'b1; ctrl_o.selMAR = MAR_EAB; ctrl_o.selEAB1 = EAB1_PC;
        ctrl_o.selEAB2 = EAB2_ZERO; ctrl_o.ldMAR = 1'b1; ctrl_o.ldPC = 1'b1;
        ctrl_o.selPC = PC_INC;
      end
      S_F2, S_MRD: begin
        ctrl_o.ldMDR = 1'b1; ctrl_o.selMDR = MDR_MEM;
      end
      S_F3: begin
        ctrl_o.enaMDR = 1'b1; ctrl_o.ldIR = 1'b1;
      end
      S_EXALU: begin
        ctrl_o.enaALU = 1'b1; ctrl_o.regWE = 1'b1; ctrl_o.flagWE = 1'b1;
        ctrl_o.DR = ir_i[11:9]; ctrl_o.SR1 = ir_i[8:6]; ctrl_o.SR2 = ir_i[2:0];
        ctrl_o.aluControl = (ir_i[15:12] == OP_AND) ? ALU_AND :
                            (ir_i[15:12] == OP_NOT) ? ALU_NOT : ALU_ADD;
      end
      S_BR: begin
        // Taken-branch load is the only output that looks past the state register.
        if ((ir_i[11] & n_i) | (ir_i[10] & z_i) | (ir_i[9] & p_i)) begin
          ctrl_o.ldPC = 1'b1; ctrl_o.selPC = PC_EAB;
          ctrl_o.selEAB1 = EAB1_PC; ctrl_o.selEAB2 = EAB2_OFF9;
        end
      end
      S_JMP: begin
        ctrl_o.ldPC = 1'b1; ctrl_o.selPC = PC_EAB; ctrl_o.selEAB1 = EAB1_RA;
        ctrl_o.selEAB2 = EAB2_ZERO; ctrl_o.SR1 = ir_i[8:6];
      end
      S_JSR1: begin
        ctrl_o.enaPC = 1'b1; ctrl_o.regWE = 1'b1; ctrl_o.DR = 3'd7;
      end
      S_JSR2: begin
        ctrl_o.ldPC = 1'b1; ctrl_o.selPC = PC_EAB;
        if (ir_i[11]) begin
          ctrl_o.selEAB1 = EAB1_PC; ctrl_o.selEAB2 = EAB2_OFF11;
        end else begin
          ctrl_o.selEAB1 = EAB1_RA; ctrl_o.selEAB2 = EAB2_ZERO; ctrl_o.SR1 = ir_i[8:6];
        end
      end
      S_LEA: begin
        ctrl_o.enaMARM = 1'b1; ctrl_o.selMAR = MAR_EAB; ctrl_o.selEAB1 = EAB1_PC;
        ctrl_o.selEAB2 = EAB2_OFF9; ctrl_o.regWE = 1'b1; ctrl_o.DR = ir_i[11:9];
      end
      S_LDA, S_STA: begin
        ctrl_o.enaMARM = 1'b1; ctrl_o.ldMAR = 1'b1; ctrl_o.selMAR = MAR_EAB;
        ctrl_o.selEAB1 = EAB1_PC; ctrl_o.selEAB2 = EAB2_OFF9;
      end
      S_LDRA, S_STRA: begin
        ctrl_o.enaMARM = 1'b1; ctrl_o.ldMAR = 1'b1; ctrl_o.selMAR = MAR_EAB;
        ctrl_o.selEAB1 = EAB1_RA; ctrl_o.selEAB2 = EAB2_OFF6; ctrl_o.SR1 = ir_i[8:6];
      end
      S_MWB: begin
        ctrl_o.enaMDR = 1'b1; ctrl_o.regWE = 1'b1; ctrl_o.flagWE = 1'b1;
        ctrl_o.DR = ir_i[11:9];
      end
      S_SD: begin
        // Store data travels through the ALU as a pass-through of the source register.
        ctrl_o.enaALU = 1'b1; ctrl_o.aluControl = ALU_PASS; ctrl_o.SR1 = ir_i[11:9];
        ctrl_o.ldMDR = 1'b1; ctrl_o.selMDR = MDR_BUS;
      end
      S_SW:    ctrl_o.memWE  = 1'b1;
      S_HALT:  ctrl_o.halted = 1'b1;
      default: ctrl_o = '0;
    endcase
  end
endmodule

// File: rtl/lc3_control.sv
// LC-3 control unit: state register, retired-instruction counter and the
// decode instance that turns the current state into datapath controls.
module lc3_control
  import lc3_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  lc3_control_if.master bus
);
  state_e      state_q;
  logic [15:0] cnt_q;
  ctrl_t       ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_INIT: state_q <= S_F1;
        S_F1:   state_q <= S_F2;
        S_F2:   state_q <= S_F3;
        S_F3:   state_q <= S_DEC;
        S_DEC: begin
          case (bus.IR[15:12])
            OP_ADD, OP_AND, OP_NOT: state_q <= S_EXALU;
            OP_BR:   state_q <= S_BR;
            OP_JMP:  state_q <= S_JMP;
            OP_JSR:  state_q <= S_JSR1;
            OP_LEA:  state_q <= S_LEA;
            OP_LD:   state_q <= S_LDA;
            OP_LDR:  state_q <= S_LDRA;
            OP_ST:   state_q <= S_STA;
            OP_STR:  state_q <= S_STRA;
            default: state_q <= S_HALT;
          endcase
        end
        S_JSR1:         state_q <= S_JSR2;
        S_LDA, S_LDRA:  state_q <= S_MRD;
        S_MRD:          state_q <= S_MWB;
        S_STA, S_STRA:  state_q <= S_SD;
        S_SD:           state_q <= S_SW;
        S_EXALU, S_BR, S_JMP, S_JSR2, S_LEA, S_MWB, S_SW: begin
          state_q <= S_F1;
          cnt_q   <= cnt_q + 16'd1;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  lc3_ctrl_decode u_dec (
    .state_i (state_q),
    .ir_i    (bus.IR),
    .n_i     (bus.N),
    .z_i     (bus.Z),
    .p_i     (bus.P),
    .ctrl_o  (ctrl)
  );

  assign bus.aluControl = ctrl.aluControl;
  assign bus.SR1        = ctrl.SR1;
  assign bus.SR2        = ctrl.SR2;
  assign bus.DR         = ctrl.DR;
  assign bus.selPC      = ctrl.selPC;
  assign bus.selEAB1    = ctrl.selEAB1;
  assign bus.selEAB2    = ctrl.selEAB2;
  assign bus.selMAR     = ctrl.selMAR;
  assign bus.selMDR     = ctrl.selMDR;
  assign bus.enaALU     = ctrl.enaALU;
  assign bus.enaMARM    = ctrl.enaMARM;
  assign bus.enaPC      = ctrl.enaPC;
  assign bus.enaMDR     = ctrl.enaMDR;
  assign bus.regWE      = ctrl.regWE;
  assign bus.flagWE     = ctrl.flagWE;
  assign bus.ldPC       = ctrl.ldPC;
  assign bus.ldIR       = ctrl.ldIR;
  assign bus.ldMAR      = ctrl.ldMAR;
  assign bus.ldMDR      = ctrl.ldMDR;
  assign bus.memWE      = ctrl.memWE;
  assign bus.halted     = ctrl.halted;
  assign bus.instrCount = cnt_q;
endmodule

// File: tb/tb_lc3_control.sv
// Random instruction stream plus directed cases; each instruction is expanded
// into its expected per-cycle control words from the instruction semantics.
module tb_lc3_control;
  import lc3_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [15:0] exp_cnt = '0;
  ctrl_t exp_q[$];

  lc3_control_if dif ();
  lc3_control dut (.clk(clk), .reset(reset), .bus(dif));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ctrl_t sample();
    ctrl_t c;
    c.aluControl = dif.aluControl; c.SR1 = dif.SR1; c.SR2 = dif.SR2; c.DR = dif.DR;
    c.selPC = dif.selPC; c.selEAB1 = dif.selEAB1; c.selEAB2 = dif.selEAB2;
    c.selMAR = dif.selMAR; c.selMDR = dif.selMDR; c.enaALU = dif.enaALU;
    c.enaMARM = dif.enaMARM; c.enaPC = dif.enaPC; c.enaMDR = dif.enaMDR;
    c.regWE = dif.regWE; c.flagWE = dif.flagWE; c.ldPC = dif.ldPC; c.ldIR = dif.ldIR;
    c.ldMAR = dif.ldMAR; c.ldMDR = dif.ldMDR; c.memWE = dif.memWE; c.halted = dif.halted;
    return c;
  endfunction

  // Expected cycle-by-cycle control words of one instruction; returns 1 if it retires.
  function automatic bit build(input logic [15:0] ir, input logic n, input logic z, input logic p);
    ctrl_t c;
    logic [3:0] op = ir[15:12];
    bit ret = 1'b1;
    exp_q.delete();
    c = '0; c.enaMARM = 1; c.ldMAR = 1; c.ldPC = 1; exp_q.push_back(c);
    c = '0; c.ldMDR = 1; c.selMDR = 1; exp_q.push_back(c);
    c = '0; c.enaMDR = 1; c.ldIR = 1; exp_q.push_back(c);
    c = '0; exp_q.push_back(c);
    c = '0;
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        c.enaALU = 1; c.regWE = 1; c.flagWE = 1;
        c.DR = ir[11:9]; c.SR1 = ir[8:6]; c.SR2 = ir[2:0];
        c.aluControl = (op == 4'b0001) ? 2'd0 : (op == 4'b0101) ? 2'd1 : 2'd2;
        exp_q.push_back(c);
      end
      4'b0000: begin
        if ((ir[11] && n) || (ir[10] && z) || (ir[9] && p)) begin
          c.ldPC = 1; c.selPC = 2'd1; c.selEAB2 = 2'd2;
        end
        exp_q.push_back(c);
      end
      4'b1100: begin
        c.ldPC = 1; c.selPC = 2'd1; c.selEAB1 = 1; c.SR1 = ir[8:6]; exp_q.push_back(c);
      end
      4'b0100: begin
        c.enaPC = 1; c.regWE = 1; c.DR = 3'd7; exp_q.push_back(c);
        c = '0; c.ldPC = 1; c.selPC = 2'd1;
        if (ir[11]) c.selEAB2 = 2'd3;
        else begin c.selEAB1 = 1; c.SR1 = ir[8:6]; end
        exp_q.push_back(c);
      end
      4'b1110: begin
        c.enaMARM = 1; c.selEAB2 = 2'd2; c.regWE = 1; c.DR = ir[11:9]; exp_q.push_back(c);
      end
      4'b0010, 4'b0110, 4'b0011, 4'b0111: begin
        c.enaMARM = 1; c.ldMAR = 1;
        if (op[2]) begin c.selEAB1 = 1; c.selEAB2 = 2'd1; c.SR1 = ir[8:6]; end
        else c.selEAB2 = 2'd2;
        exp_q.push_back(c);
        if (!op[0]) begin
          c = '0; c.ldMDR = 1; c.selMDR = 1; exp_q.push_back(c);
          c = '0; c.enaMDR = 1; c.regWE = 1; c.flagWE = 1; c.DR = ir[11:9]; exp_q.push_back(c);
        end else begin
          c = '0; c.enaALU = 1; c.aluControl = 2'd3; c.SR1 = ir[11:9]; c.ldMDR = 1;
          exp_q.push_back(c);
          c = '0; c.memWE = 1; exp_q.push_back(c);
        end
      end
      default: begin
        ret = 1'b0;
        c.halted = 1;
        for (int k = 0; k < 5; k++) exp_q.push_back(c);
      end
    endcase
    return ret;
  endfunction

  // Called at posedge+2 of an F1 cycle; returns at posedge+2 of the next F1.
  // abort_at >= 0 asserts reset asynchronously right after that cycle's check.
  task automatic run_instr(input logic [15:0] ir, input logic n, input logic z,
                           input logic p, input int abort_at);
    ctrl_t g;
    bit ret;
    int en;
    dif.IR = ir; dif.N = n; dif.Z = z; dif.P = p;
    ret = build(ir, n, z, p);
    #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin @(posedge clk); #2; end
      g = sample();
      chk($sformatf("ctl ir=%h cyc=%0d", ir, i), 32'(g), 32'(exp_q[i]));
      en = int'(g.enaALU) + int'(g.enaMARM) + int'(g.enaPC) + int'(g.enaMDR);
      chk("bus_excl", 32'(en <= 1), 32'd1);
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        exp_cnt = '0;
        chk("abort_ctl", 32'(sample()), 32'd0);
        chk("abort_cnt", 32'(dif.instrCount), 32'(exp_cnt));
        @(posedge clk); #3;
        chk("abort_hold", 32'(sample()), 32'd0);
        reset = 1'b0;
        @(posedge clk); #2;
        return;
      end
    end
    @(posedge clk); #2;
    if (ret) exp_cnt = exp_cnt + 16'd1;
    else chk("halt_stay", 32'(dif.halted), 32'd1);
    chk("cnt", 32'(dif.instrCount), 32'(exp_cnt));
  endtask

  localparam int NOPS = 11;
  logic [3:0] ops [NOPS] = '{4'h1, 4'h5, 4'h9, 4'h0, 4'hC, 4'h4, 4'hE, 4'h2, 4'h6, 4'h3, 4'h7};

  initial begin
    logic [15:0] ir;
    dif.IR = '0; dif.N = 0; dif.Z = 0; dif.P = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("rst_ctl", 32'(sample()), 32'd0);
      chk("rst_cnt", 32'(dif.instrCount), 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("init_ctl", 32'(sample()), 32'd0);
    @(posedge clk); #2;

    run_instr(16'h1283, 0, 0, 0, -1);
    run_instr(16'h0A05, 0, 1, 0, -1);
    run_instr(16'h0A05, 1, 0, 0, -1);
    run_instr(16'h6442, 0, 0, 1, -1);
    run_instr(16'h3602, 0, 0, 0, -1);
    run_instr(16'h4803, 0, 0, 0, -1);
    run_instr(16'h4140, 0, 0, 0, -1);

    for (int t = 0; t < 150; t++) begin
      ir = {ops[$urandom_range(NOPS - 1)], 12'($urandom)};
      run_instr(ir, 1'($urandom), 1'($urandom), 1'($urandom), -1);
    end

    run_instr(16'h2402, 0, 0, 0, 5);
    run_instr(16'h5A7F, 0, 0, 0, -1);
    run_instr(16'hF025, 0, 0, 0, -1);
    repeat (3) @(posedge clk);
    #2;
    chk("halt_hold", 32'(dif.halted), 32'd1);
    chk("halt_cnt", 32'(dif.instrCount), 32'(exp_cnt));
    reset = 1'b1;
    #1;
    chk("halt_rst", 32'(sample()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lc3_control.md
# lc3_control

Microsequenced control unit for the LC-3 datapath. It is the counterpart of the datapath's control-input interface: it consumes the datapath's instruction register and N/Z/P flags and drives every datapath select, enable, load and write strobe. It is a Moore FSM that runs fetch, decode and execute for an LC-3 instruction subset. It also keeps a retired-instruction counter and enters a halt state on unsupported opcodes.

## Interface
- Parameters: none. Encodings are fixed in `lc3_pkg`.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; one clock domain
- IR  input  16  datapath instruction register
- N, Z, P  input  1 each  datapath condition flags
- aluControl  output  2  00 ADD, 01 AND, 10 NOT, 11 PASS(Ra)
- SR1, SR2, DR  output  3 each  register-file addresses; Ra reads SR1, Rb reads SR2
- selPC  output  2  00 PC+1, 01 eabOut, 10 Buss
- selEAB1  output  1  0 PC, 1 Ra
- selEAB2  output  2  00 zero, 01 sext IR[5:0], 10 sext IR[8:0], 11 sext IR[10:0]
- selMAR  output  1  0 eabOut, 1 zext IR[7:0]
- selMDR  output  1  0 Buss, 1 memory
- enaALU, enaMARM, enaPC, enaMDR  output  1 each  bus drivers; at most one is high per cycle
- regWE, flagWE, ldPC, ldIR, ldMAR, ldMDR, memWE  output  1 each  load/write strobes
- halted  output  1  high in HALT
- instrCount  output  16  retired-instruction count

## Operation
- All outputs are a combinational decode of the state register only. The one exception is the BR ldPC term (see BR below).
- Any output not listed for a state is 0.
- INIT: all outputs 0. Next state is F1.
- F1: enaMARM, selMAR=0, selEAB1=0, selEAB2=00, ldMAR, ldPC, selPC=00. Effect: MAR←PC, PC←PC+1.
- F2: ldMDR, selMDR=1.
- F3: enaMDR, ldIR.
- DEC: no strobes. Branches on IR[15:12]:
  - 0001, 0101, 1001 → EXALU
  - 0000 → BR
  - 1100 → JMP
  - 0100 → JSR1
  - 1110 → LEA
  - 0010 → LDA
  - 0110 → LDRA
  - 0011 → STA
  - 0111 → STRA
  - all others → HALT
- EXALU: enaALU, regWE, flagWE, DR=IR[11:9], SR1=IR[8:6], SR2=IR[2:0]. aluControl=00/01/10 for ADD/AND/NOT. The datapath handles IR[5] immediate selection.
- BR: taken = (IR[11]&N)|(IR[10]&Z)|(IR[9]&P). When taken: ldPC, selPC=01, selEAB1=0, selEAB2=10. Otherwise no strobes.
- JMP: ldPC, selPC=01, selEAB1=1, selEAB2=00, SR1=IR[8:6].
- JSR1: enaPC, regWE, DR=7.
- JSR2: ldPC, selPC=01.
  - If IR[11]=1: selEAB1=0, selEAB2=11.
  - If IR[11]=0 (JSRR): selEAB1=1, selEAB2=00, SR1=IR[8:6].
  - JSRR with BaseR=R7 jumps to the return address. This is a documented limitation.
- LEA: enaMARM, selMAR=0, selEAB1=0, selEAB2=10, regWE, DR=IR[11:9]. flagWE=0.
- LDA / STA: enaMARM, ldMAR, selMAR=0, selEAB1=0, selEAB2=10.
- LDRA / STRA: same as LDA/STA but selEAB1=1, selEAB2=01, SR1=IR[8:6].
- Load path: LDA/LDRA → MRD, then MWB.
  - MRD: ldMDR, selMDR=1.
  - MWB: enaMDR, regWE, flagWE, DR=IR[11:9].
- Store path: STA/STRA → SD, then SW.
  - SD: enaALU, aluControl=11, SR1=IR[11:9], ldMDR, selMDR=0.
  - SW: memWE.
- Last state of each instruction returns to F1: EXALU, BR, JMP, JSR2, LEA, MWB, SW.
- instrCount increments by 1 on the clock edge leaving each last state and wraps 0xFFFF→0. It holds in HALT.
- HALT: all strobes 0, halted=1. Self-loops until reset.

## Timing
- Reset is asynchronous. While reset is high: state=INIT, instrCount=0, every output 0 (including SR1/SR2/DR and halted).
- Reset asserted mid-instruction aborts it immediately. No strobe is asserted after reset rises.
- First F1 occurs one cycle after reset falls.
- Cycles per instruction, counted from F1:
  - ADD/AND/NOT, BR, JMP, LEA: 5
  - JSR/JSRR: 6
  - LD, LDR, ST, STR: 7
- BR samples N/Z/P in the BR cycle. Flags written by the previous instruction's final edge are visible.
- DEC samples IR loaded at the end of F3.

## Structure
- `lc3_pkg` holds:
  - state enum
  - opcode constants
  - aluControl, selPC and selEAB2 encodings
  - selMAR, selMDR and selEAB1 encodings
- Optional single sub-module `lc3_ctrl_decode`: purely combinational, maps state, IR and flags to all outputs. The top module holds the state register and instrCount.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; INIT, then F1 with ldMAR=ldPC=enaMARM=1.
- IR=0x1283 (ADD R1,R2,R3) → cycle 5: enaALU=regWE=flagWE=1, DR=1, SR1=2, SR2=3, aluControl=00; instrCount=1 after.
- IR=0x0A05 (BRnp):
  - Z=1 → BR cycle has ldPC=0.
  - N=1 → ldPC=1, selPC=01, selEAB2=10.
- IR=0x6442 (LDR R2,R1,#2) → LDRA: SR1=1, selEAB1=1, selEAB2=01; MRD: selMDR=1; MWB: DR=2, flagWE=1; 7 cycles total.
- IR=0x3602 (ST R3) → SD: SR1=3, aluControl=11, selMDR=0; SW: memWE=1 for exactly one cycle.
- IR=0xF025 (TRAP, unsupported) → HALT with halted=1 and count frozen. Reset asserted mid-LD (MRD) → INIT with outputs 0 asynchronously.
